// File: rtl/instr_decoder.sv
//==============================================================================
// Module      : instr_decoder
// Description : Decode-side producer for the decoded-instruction pipeline
//               register. Assembles one-word (format=0) or two-word
//               (format=1 header + immediate) instructions from a raw word
//               stream and presents a registered field bundle.
// Ports       : clock, reset          - clock, synchronous active-high reset
//               in_valid/in_ready     - raw word handshake (in_word)
//               out_valid/out_ready   - decoded bundle handshake
//               out_format, out_opcode, out_sign, out_operand, out_immediate
//               out_error             - only with INSTR_DECODER_IMM_CHECK_EN
// Options     : INSTR_DECODER_IMM_CHECK_EN - flag immediate words whose top
//               bit is set via out_error.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module instr_decoder #(
  parameter int OPCODE_W  = 4,
  parameter int OPERAND_W = 3,
  parameter int IMM_W     = 8,
  localparam int WORD_W   = 2 + OPCODE_W + OPERAND_W
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_W-1:0]    in_word,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_format,
  output logic [OPCODE_W-1:0]  out_opcode,
  output logic                 out_sign,
  output logic [OPERAND_W-1:0] out_operand,
  output logic [IMM_W-1:0]     out_immediate
`ifdef INSTR_DECODER_IMM_CHECK_EN
  ,
  output logic                 out_error
`endif
);

  if (IMM_W > WORD_W - 1) begin : g_bad_imm_w
    $error("instr_decoder: IMM_W must be <= WORD_W-1");
  end

  typedef enum logic [1:0] {
    S_HDR = 2'd0,
    S_IMM = 2'd1,
    S_OUT = 2'd2
  } state_t;

  state_t state, state_next;

  // Header fields of a format=1 instruction waiting for its immediate word.
  logic [OPCODE_W-1:0]  pend_opcode;
  logic                 pend_sign;
  logic [OPERAND_W-1:0] pend_operand;

  // Field views of the incoming word when treated as a header.
  logic                 hdr_format;
  logic [OPCODE_W-1:0]  hdr_opcode;
  logic                 hdr_sign;
  logic [OPERAND_W-1:0] hdr_operand;

  assign hdr_format  = in_word[WORD_W-1];
  assign hdr_opcode  = in_word[WORD_W-2 -: OPCODE_W];
  assign hdr_sign    = in_word[OPERAND_W];
  assign hdr_operand = in_word[OPERAND_W-1:0];

  logic accept;
  logic consume;
  logic load_pend;   // format=1 header accepted
  logic load_hdr;    // format=0 header accepted -> bundle with zero immediate
  logic load_imm;    // immediate accepted -> bundle from pending header

  // The bundle is valid exactly while holding in S_OUT, so out_valid is a
  // pure decode of the state register.
  assign out_valid = (state == S_OUT);
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;

  // In S_OUT a new word may only enter when the held bundle leaves in the
  // same cycle, which gives back-to-back pass-through without a bubble.
  always_comb begin
    in_ready = 1'b0;
    if (!reset) begin
      case (state)
        S_OUT:   in_ready = out_ready;
        default: in_ready = 1'b1;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    load_pend  = 1'b0;
    load_hdr   = 1'b0;
    load_imm   = 1'b0;
    case (state)
      S_HDR: begin
        if (accept) begin
          if (hdr_format) begin
            load_pend  = 1'b1;
            state_next = S_IMM;
          end else begin
            load_hdr   = 1'b1;
            state_next = S_OUT;
          end
        end
      end
      S_IMM: begin
        if (accept) begin
          load_imm   = 1'b1;
          state_next = S_OUT;
        end
      end
      S_OUT: begin
        // accept implies consume here, since in_ready follows out_ready.
        if (consume) begin
          if (accept) begin
            if (hdr_format) begin
              load_pend  = 1'b1;
              state_next = S_IMM;
            end else begin
              load_hdr   = 1'b1;
              state_next = S_OUT;
            end
          end else begin
            state_next = S_HDR;
          end
        end
      end
      default: state_next = S_HDR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= S_HDR;
      pend_opcode   <= '0;
      pend_sign     <= 1'b0;
      pend_operand  <= '0;
      out_format    <= 1'b0;
      out_opcode    <= '0;
      out_sign      <= 1'b0;
      out_operand   <= '0;
      out_immediate <= '0;
    end else begin
      state <= state_next;
      if (load_pend) begin
        pend_opcode  <= hdr_opcode;
        pend_sign    <= hdr_sign;
        pend_operand <= hdr_operand;
      end
      if (load_hdr) begin
        out_format    <= 1'b0;
        out_opcode    <= hdr_opcode;
        out_sign      <= hdr_sign;
        out_operand   <= hdr_operand;
        out_immediate <= '0;
      end
      if (load_imm) begin
        // Only format=1 headers ever reach S_IMM, so the format is known.
        out_format    <= 1'b1;
        out_opcode    <= pend_opcode;
        out_sign      <= pend_sign;
        out_operand   <= pend_operand;
        out_immediate <= in_word[IMM_W-1:0];
      end
    end
  end

`ifdef INSTR_DECODER_IMM_CHECK_EN
  // Error tracks the bundle: set by a tainted immediate, cleared by any
  // other bundle load.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_error <= 1'b0;
    end else if (load_hdr) begin
      out_error <= 1'b0;
    end else if (load_imm) begin
      out_error <= in_word[WORD_W-1];
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_decoder.sv
//==============================================================================
// Module      : tb_instr_decoder
// Description : Self-checking bench for instr_decoder. Hand-written corner
//               sequences followed by a table of instructions driven under
//               random out_ready back-pressure; a scoreboard queue holds the
//               expected bundles.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_instr_decoder;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [8:0] in_word = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_format;
  logic [3:0] out_opcode;
  logic       out_sign;
  logic [2:0] out_operand;
  logic [7:0] out_immediate;
  logic       act_err;

`ifdef INSTR_DECODER_IMM_CHECK_EN
  localparam bit ERR_EN = 1'b1;
  logic out_error;
  assign act_err = out_error;
`else
  localparam bit ERR_EN = 1'b0;
  assign act_err = 1'b0;
`endif

  instr_decoder dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_word      (in_word),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_format   (out_format),
    .out_opcode   (out_opcode),
    .out_sign     (out_sign),
    .out_operand  (out_operand),
    .out_immediate(out_immediate)
`ifdef INSTR_DECODER_IMM_CHECK_EN
    ,
    .out_error    (out_error)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       fmt;
    logic [3:0] op;
    logic       sign;
    logic [2:0] opnd;
    logic [7:0] imm;
    logic       err;
  } bundle_t;

  typedef struct {
    logic [8:0] hdr;
    logic [8:0] imm_word;
    logic       two;
    logic [3:0] op;
    logic       sign;
    logic [2:0] opnd;
    logic [7:0] imm;
    logic       err;
  } vec_t;

  bundle_t q[$];
  int tests = 0;
  int fails = 0;
  int stalls;
  bit rand_mode = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bundle_t mk(input logic fmt, input logic [3:0] op, input logic s,
                                 input logic [2:0] o, input logic [7:0] imm, input logic err);
    bundle_t b;
    b.fmt = fmt; b.op = op; b.sign = s; b.opnd = o; b.imm = imm; b.err = err & ERR_EN;
    return b;
  endfunction

  function automatic bundle_t act_bundle();
    bundle_t b;
    b.fmt = out_format; b.op = out_opcode; b.sign = out_sign;
    b.opnd = out_operand; b.imm = out_immediate; b.err = act_err;
    return b;
  endfunction

  // Scoreboard: each bundle seen with out_valid && out_ready is consumed at
  // the following posedge, so it is compared exactly once here.
  initial begin
    bundle_t e;
    forever begin
      @(negedge clock);
      if (!reset && out_valid && out_ready) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_bundle: got %h expected none at %0t", act_bundle(), $time);
        end else begin
          e = q.pop_front();
          chk("bundle", 32'(act_bundle()), 32'(e));
        end
      end
    end
  end

  // Random back-pressure for the table phase.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Present a word and return 1 time unit after the posedge that accepts it.
  task automatic send_word(input logic [8:0] w);
    stalls = 0;
    in_valid = 1'b1;
    in_word  = w;
    forever begin
      @(negedge clock);
      if (in_ready) begin
        @(posedge clock);
        #1;
        break;
      end
      stalls++;
      if (stalls > 50) begin
        tests++;
        fails++;
        $display("FAIL send_timeout: got in_ready=0 expected 1 word=%h", w);
        @(posedge clock);
        #1;
        break;
      end
      @(posedge clock);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_word  = 9'($urandom);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b1;
    in_word  = 9'($urandom);
    q.delete();
    @(negedge clock);
    chk("in_ready_in_reset", 32'(in_ready), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    idle();
    @(negedge clock);
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_fields", 32'(act_bundle()), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clock);
    #1;
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{9'b0_0011_1_101, 9'h000, 1'b0, 4'd3,  1'b1, 3'd5, 8'h00, 1'b0};
    vecs[1] = '{9'b1_1010_0_010, 9'h0A5, 1'b1, 4'd10, 1'b0, 3'd2, 8'hA5, 1'b0};
    vecs[2] = '{9'b1_0101_1_001, 9'h1C3, 1'b1, 4'd5,  1'b1, 3'd1, 8'hC3, 1'b1};
    vecs[3] = '{9'b0_1111_0_000, 9'h000, 1'b0, 4'd15, 1'b0, 3'd0, 8'h00, 1'b0};
    vecs[4] = '{9'b1_0000_1_111, 9'h0FF, 1'b1, 4'd0,  1'b1, 3'd7, 8'hFF, 1'b0};
    vecs[5] = '{9'b1_0110_1_011, 9'h13C, 1'b1, 4'd6,  1'b1, 3'd3, 8'h3C, 1'b1};
    vecs[6] = '{9'b1_1100_0_100, 9'h000, 1'b1, 4'd12, 1'b0, 3'd4, 8'h00, 1'b0};
    vecs[7] = '{9'b0_1001_0_110, 9'h000, 1'b0, 4'd9,  1'b0, 3'd6, 8'h00, 1'b0};

    repeat (2) @(posedge clock);
    #1;
    do_reset();

    // Single format=0 header: valid one cycle later, then drops.
    out_ready = 1'b1;
    send_word(9'b0_0011_1_101);
    q.push_back(mk(1'b0, 4'd3, 1'b1, 3'd5, 8'h00, 1'b0));
    idle();
    @(negedge clock);
    chk("fmt0_latency", 32'(out_valid), 32'd1);
    @(posedge clock);
    #1;
    @(negedge clock);
    chk("fmt0_drop", 32'(out_valid), 32'd0);
    @(posedge clock);
    #1;

    // Two-word instruction with the pending header held across idle cycles.
    send_word(9'b1_1010_0_010);
    idle();
    repeat (3) begin
      @(negedge clock);
      chk("fmt1_no_valid", 32'(out_valid), 32'd0);
      @(posedge clock);
      #1;
    end
    send_word(9'h0A5);
    q.push_back(mk(1'b1, 4'd10, 1'b0, 3'd2, 8'hA5, 1'b0));
    idle();
    @(negedge clock);
    chk("fmt1_latency", 32'(out_valid), 32'd1);
    @(posedge clock);
    #1;

    // Back-to-back stream of format=0 headers.
    send_word(9'b0_0001_0_001);
    q.push_back(mk(1'b0, 4'd1, 1'b0, 3'd1, 8'h00, 1'b0));
    send_word(9'b0_0010_1_010);
    chk("stream_stall2", 32'(stalls), 32'd0);
    q.push_back(mk(1'b0, 4'd2, 1'b1, 3'd2, 8'h00, 1'b0));
    send_word(9'b0_0100_0_100);
    chk("stream_stall3", 32'(stalls), 32'd0);
    q.push_back(mk(1'b0, 4'd4, 1'b0, 3'd4, 8'h00, 1'b0));
    idle();
    @(negedge clock);
    chk("stream_valid3", 32'(out_valid), 32'd1);
    @(posedge clock);
    #1;

    // Held bundle under back-pressure, then same-cycle handoff.
    out_ready = 1'b0;
    send_word(9'b0_0111_1_011);
    q.push_back(mk(1'b0, 4'd7, 1'b1, 3'd3, 8'h00, 1'b0));
    in_word = 9'b0_1000_0_110;
    repeat (5) begin
      @(negedge clock);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_fields", 32'(act_bundle()), 32'(mk(1'b0, 4'd7, 1'b1, 3'd3, 8'h00, 1'b0)));
      @(posedge clock);
      #1;
    end
    out_ready = 1'b1;
    send_word(9'b0_1000_0_110);
    chk("handoff_stall", 32'(stalls), 32'd0);
    q.push_back(mk(1'b0, 4'd8, 1'b0, 3'd6, 8'h00, 1'b0));
    idle();
    repeat (2) @(posedge clock);
    #1;

    // Reset while waiting for an immediate discards the pending header.
    send_word(9'h1F3);
    idle();
    @(posedge clock);
    #1;
    do_reset();
    send_word(9'b0_0110_0_111);
    q.push_back(mk(1'b0, 4'd6, 1'b0, 3'd7, 8'h00, 1'b0));
    idle();
    repeat (2) @(posedge clock);
    #1;

    // Reset while a bundle is held.
    out_ready = 1'b0;
    send_word(9'b0_1011_1_001);
    idle();
    @(posedge clock);
    #1;
    do_reset();
    out_ready = 1'b1;

    // Table phase under random back-pressure.
    rand_mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_word(vecs[i].hdr);
      if (vecs[i].two) send_word(vecs[i].imm_word);
      q.push_back(mk(vecs[i].two, vecs[i].op, vecs[i].sign, vecs[i].opnd,
                     vecs[i].imm, vecs[i].err));
      if ($urandom_range(0, 1) == 1) idle();
    end
    idle();
    rand_mode = 1'b0;
    @(posedge clock);
    #2;
    out_ready = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
